// File: rtl/pe_control_v2.sv
// Eyeriss PE controller: decodes TOP CTRL instructions and sequences spad addresses/enables; one-cycle DEC after accept.
// FIFO readies depend on state only; stalls freeze counters. Optional psum drain path enabled by PE_CTRL_DRAIN_EN.
module pe_control_v2 #(
  parameter int DIM_BITWIDTH        = 3,
  parameter int IFMAP_ADDR_BITWIDTH = 4,
  parameter int WGHT_ADDR_BITWIDTH  = 8,
  parameter int PSUM_ADDR_BITWIDTH  = 5
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [2:0]                     i_opcode,
  input  logic [3*DIM_BITWIDTH-1:0]      i_conv_info,
  input  logic                           i_inst_valid,
  output logic                           o_inst_ready,
  input  logic                           i_ifmap_fifo_valid,
  output logic                           o_ifmap_fifo_ready,
  input  logic                           i_wght_fifo_valid,
  output logic                           o_wght_fifo_ready,
  input  logic                           i_psum_in_fifo_valid,
  output logic                           o_psum_in_fifo_ready,
  output logic                           o_psum_out_valid,
  input  logic                           i_psum_out_fifo_ready,
  output logic                           o_ifmap_mux_select,
  output logic                           o_wght_mux_select,
  output logic                           o_psum_in_mux_select,
  output logic                           o_psum_out_demux_select,
  output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_ra,
  output logic [IFMAP_ADDR_BITWIDTH-1:0] o_ifmap_wa,
  output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_ra,
  output logic [WGHT_ADDR_BITWIDTH-1:0]  o_wght_wa,
  output logic [PSUM_ADDR_BITWIDTH-1:0]  o_psum_ra,
  output logic [PSUM_ADDR_BITWIDTH-1:0]  o_psum_wa,
  output logic                           o_ifmap_we,
  output logic                           o_wght_we,
  output logic                           o_psum_we,
  output logic                           o_acc_sel,
  output logic                           o_rst_psum,
  output logic                           o_err
);

  localparam int D  = DIM_BITWIDTH;
  localparam int CW = 3 * DIM_BITWIDTH;
  localparam int IW = IFMAP_ADDR_BITWIDTH;
  localparam int WW = WGHT_ADDR_BITWIDTH;
  localparam int PW = PSUM_ADDR_BITWIDTH;
  localparam logic [D-1:0]  D_ONE = 1;
  localparam logic [CW-1:0] C_ONE = 1;

  localparam logic [2:0] OP_NOP = 3'b000, OP_SET = 3'b001, OP_LD_IFMAP = 3'b010,
                         OP_LD_WGHT = 3'b011, OP_CONV = 3'b100, OP_ACC = 3'b101,
                         OP_DRAIN = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_LD_IFMAP, S_LD_WGHT, S_CONV, S_ACC, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    opcode_q;
  logic [CW-1:0] info_q;
  logic [D-1:0]  cfg_p, cfg_q, cfg_s;
  logic          cfg_valid;
  logic          err_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D-1:0]  p_q, p_d, q_q, q_d, s_q, s_d;
  logic [CW-1:0] qs_q, qs_d;

  // Capacity check on the pending SET operands, products at full width.
  logic [D-1:0]  in_p, in_q, in_s;
  logic [CW-1:0] prod_qs, prod_pqs;
  logic          set_ok;
  assign in_p     = info_q[3*D-1:2*D];
  assign in_q     = info_q[2*D-1:D];
  assign in_s     = info_q[D-1:0];
  assign prod_qs  = CW'(in_q) * CW'(in_s);
  assign prod_pqs = prod_qs * CW'(in_p);
  assign set_ok   = (|in_p) && (|in_q) && (|in_s)
                 && (64'(prod_qs)  <= (64'd1 << IW))
                 && (64'(prod_pqs) <= (64'd1 << WW))
                 && (64'(in_p)     <= (64'd1 << PW));

  logic [CW-1:0] n_ifmap, n_wght;
  assign n_ifmap = CW'(cfg_q) * CW'(cfg_s);
  assign n_wght  = n_ifmap * CW'(cfg_p);

  logic op_legal;
  always_comb begin
    op_legal = 1'b0;
    case (opcode_q)
      OP_NOP, OP_SET:                   op_legal = 1'b1;
      OP_LD_IFMAP, OP_LD_WGHT, OP_CONV,
      OP_ACC:                           op_legal = cfg_valid;
`ifdef PE_CTRL_DRAIN_EN
      OP_DRAIN:                         op_legal = cfg_valid;
`endif
      default:                          op_legal = 1'b0;
    endcase
  end

`ifndef PE_CTRL_DRAIN_EN
  logic unused_drain_rdy;
  assign unused_drain_rdy = i_psum_out_fifo_ready;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= OP_NOP;
      info_q    <= '0;
      cfg_p     <= '0;
      cfg_q     <= '0;
      cfg_s     <= '0;
      cfg_valid <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      s_q       <= '0;
      qs_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      s_q     <= s_d;
      qs_q    <= qs_d;
      if (state_q == S_IDLE && i_inst_valid) begin
        opcode_q <= i_opcode;
        info_q   <= i_conv_info;
      end
      if (state_q == S_DEC) begin
        if (opcode_q == OP_SET) begin
          if (set_ok) begin
            cfg_p     <= in_p;
            cfg_q     <= in_q;
            cfg_s     <= in_s;
            cfg_valid <= 1'b1;
            err_q     <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end else if (!op_legal) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d                 = state_q;
    cnt_d                   = cnt_q;
    p_d                     = p_q;
    q_d                     = q_q;
    s_d                     = s_q;
    qs_d                    = qs_q;
    o_inst_ready            = 1'b0;
    o_ifmap_fifo_ready      = 1'b0;
    o_wght_fifo_ready       = 1'b0;
    o_psum_in_fifo_ready    = 1'b0;
    o_psum_out_valid        = 1'b0;
    o_ifmap_mux_select      = 1'b0;
    o_wght_mux_select       = 1'b0;
    o_psum_in_mux_select    = 1'b0;
    o_psum_out_demux_select = 1'b0;
    o_ifmap_ra              = '0;
    o_ifmap_wa              = '0;
    o_wght_ra               = '0;
    o_wght_wa               = '0;
    o_psum_ra               = '0;
    o_psum_wa               = '0;
    o_ifmap_we              = 1'b0;
    o_wght_we               = 1'b0;
    o_psum_we               = 1'b0;
    o_acc_sel               = 1'b0;
    o_rst_psum              = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_inst_ready = 1'b1;
        if (i_inst_valid) state_d = S_DEC;
      end
      S_DEC: begin
        state_d = S_IDLE;
        if (op_legal) begin
          case (opcode_q)
            OP_LD_IFMAP: state_d = S_LD_IFMAP;
            OP_LD_WGHT:  state_d = S_LD_WGHT;
            OP_CONV:     state_d = S_CONV;
            OP_ACC:      state_d = S_ACC;
`ifdef PE_CTRL_DRAIN_EN
            OP_DRAIN:    state_d = S_DRAIN;
`endif
            default:     state_d = S_IDLE;
          endcase
        end
      end
      S_LD_IFMAP: begin
        o_ifmap_fifo_ready = 1'b1;
        o_ifmap_mux_select = 1'b1;
        o_ifmap_wa         = IW'(cnt_q);
        if (i_ifmap_fifo_valid) begin
          o_ifmap_we = 1'b1;
          if (cnt_q == n_ifmap - C_ONE) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
      end
      S_LD_WGHT: begin
        o_wght_fifo_ready = 1'b1;
        o_wght_mux_select = 1'b1;
        o_wght_wa         = WW'(cnt_q);
        if (i_wght_fifo_valid) begin
          o_wght_we = 1'b1;
          if (cnt_q == n_wght - C_ONE) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
      end
      S_CONV: begin
        // qs tracks q*S+s so only the weight address needs a multiply.
        o_ifmap_ra = IW'(qs_q);
        o_wght_ra  = WW'(qs_q * CW'(cfg_p) + CW'(p_q));
        o_psum_ra  = PW'(p_q);
        o_psum_wa  = PW'(p_q);
        o_psum_we  = 1'b1;
        o_rst_psum = (q_q == '0) && (s_q == '0);
        if (s_q == cfg_s - D_ONE) begin
          s_d = '0;
          if (q_q == cfg_q - D_ONE) begin
            q_d  = '0;
            qs_d = '0;
            if (p_q == cfg_p - D_ONE) begin
              p_d     = '0;
              state_d = S_IDLE;
            end else begin
              p_d = p_q + D_ONE;
            end
          end else begin
            q_d  = q_q + D_ONE;
            qs_d = qs_q + C_ONE;
          end
        end else begin
          s_d  = s_q + D_ONE;
          qs_d = qs_q + C_ONE;
        end
      end
      S_ACC: begin
        o_psum_in_fifo_ready = 1'b1;
        o_psum_in_mux_select = 1'b1;
        o_acc_sel            = 1'b1;
        o_psum_ra            = PW'(p_q);
        o_psum_wa            = PW'(p_q);
        if (i_psum_in_fifo_valid) begin
          o_psum_we = 1'b1;
          if (p_q == cfg_p - D_ONE) begin
            p_d     = '0;
            state_d = S_IDLE;
          end else begin
            p_d = p_q + D_ONE;
          end
        end
      end
`ifdef PE_CTRL_DRAIN_EN
      S_DRAIN: begin
        o_psum_out_valid        = 1'b1;
        o_psum_out_demux_select = 1'b1;
        o_psum_ra               = PW'(p_q);
        if (i_psum_out_fifo_ready) begin
          if (p_q == cfg_p - D_ONE) begin
            p_d     = '0;
            state_d = S_IDLE;
          end else begin
            p_d = p_q + D_ONE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_pe_control_v2.sv
// Directed bench for pe_control_v2: reset, SET/load/conv/acc/drain sequencing and error handling.
module tb_pe_control_v2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [2:0]  i_opcode = '0;
  logic [8:0]  i_conv_info = '0;
  logic        i_inst_valid = 1'b0;
  logic        i_ifmap_fifo_valid = 1'b0;
  logic        i_wght_fifo_valid = 1'b0;
  logic        i_psum_in_fifo_valid = 1'b0;
  logic        i_psum_out_fifo_ready = 1'b0;
  logic        o_inst_ready, o_ifmap_fifo_ready, o_wght_fifo_ready, o_psum_in_fifo_ready;
  logic        o_psum_out_valid, o_ifmap_mux_select, o_wght_mux_select;
  logic        o_psum_in_mux_select, o_psum_out_demux_select;
  logic [3:0]  o_ifmap_ra, o_ifmap_wa;
  logic [7:0]  o_wght_ra, o_wght_wa;
  logic [4:0]  o_psum_ra, o_psum_wa;
  logic        o_ifmap_we, o_wght_we, o_psum_we, o_acc_sel, o_rst_psum, o_err;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  pe_control_v2 dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_conv_info(i_conv_info),
    .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
    .i_ifmap_fifo_valid(i_ifmap_fifo_valid), .o_ifmap_fifo_ready(o_ifmap_fifo_ready),
    .i_wght_fifo_valid(i_wght_fifo_valid), .o_wght_fifo_ready(o_wght_fifo_ready),
    .i_psum_in_fifo_valid(i_psum_in_fifo_valid), .o_psum_in_fifo_ready(o_psum_in_fifo_ready),
    .o_psum_out_valid(o_psum_out_valid), .i_psum_out_fifo_ready(i_psum_out_fifo_ready),
    .o_ifmap_mux_select(o_ifmap_mux_select), .o_wght_mux_select(o_wght_mux_select),
    .o_psum_in_mux_select(o_psum_in_mux_select), .o_psum_out_demux_select(o_psum_out_demux_select),
    .o_ifmap_ra(o_ifmap_ra), .o_ifmap_wa(o_ifmap_wa), .o_wght_ra(o_wght_ra), .o_wght_wa(o_wght_wa),
    .o_psum_ra(o_psum_ra), .o_psum_wa(o_psum_wa), .o_ifmap_we(o_ifmap_we), .o_wght_we(o_wght_we),
    .o_psum_we(o_psum_we), .o_acc_sel(o_acc_sel), .o_rst_psum(o_rst_psum), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge inside the DEC cycle.
  task automatic issue(input logic [2:0] op, input logic [2:0] p, input logic [2:0] q, input logic [2:0] s);
    @(negedge i_clk);
    i_opcode     = op;
    i_conv_info  = {p, q, s};
    i_inst_valid = 1'b1;
    for (int w = 0; w < 300 && !o_inst_ready; w++) @(negedge i_clk);
    if (!o_inst_ready) chk("issue_timeout", 0, 1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_inst_valid = 1'b0;
    i_opcode     = '0;
  endtask

  // kind: 0 ifmap, 1 wght, 2 acc, 3 drain. alt=1 throttles valid/ready to every other cycle.
  task automatic stream(input int kind, input bit alt, input int exp_words, input int exp_cycles, input string tag);
    int words = 0;
    int cycles = 0;
    int stray = 0;
    bit v;
    for (int c = 0; c < 400; c++) begin
      @(negedge i_clk);
      v = alt ? (c % 2 == 0) : 1'b1;
      i_ifmap_fifo_valid    = (kind == 0) && v;
      i_wght_fifo_valid     = (kind == 1) && v;
      i_psum_in_fifo_valid  = (kind == 2) && v;
      i_psum_out_fifo_ready = (kind == 3) && v;
      #1;
      if (o_inst_ready) break;
      cycles++;
      case (kind)
        0: begin
          if (!o_ifmap_fifo_ready || !o_ifmap_mux_select || (o_ifmap_we && !v)) stray++;
          if (o_ifmap_we) begin chk({tag, "_wa"}, o_ifmap_wa, words); words++; end
        end
        1: begin
          if (!o_wght_fifo_ready || !o_wght_mux_select || (o_wght_we && !v)) stray++;
          if (o_wght_we) begin chk({tag, "_wa"}, o_wght_wa, words); words++; end
        end
        2: begin
          if (!o_psum_in_fifo_ready || !o_acc_sel || !o_psum_in_mux_select || (o_psum_we && !v)) stray++;
          if (o_psum_we) begin chk({tag, "_ra_wa"}, {o_psum_ra, o_psum_wa}, {5'(words), 5'(words)}); words++; end
        end
        default: begin
          if (!o_psum_out_valid || !o_psum_out_demux_select || o_psum_we) stray++;
          if (v) begin chk({tag, "_ra"}, o_psum_ra, words); words++; end
        end
      endcase
    end
    i_ifmap_fifo_valid = 0; i_wght_fifo_valid = 0; i_psum_in_fifo_valid = 0; i_psum_out_fifo_ready = 0;
    chk({tag, "_words"}, words, exp_words);
    chk({tag, "_cycles"}, cycles, exp_cycles);
    chk({tag, "_strobes"}, stray, 0);
  endtask

  task automatic run_conv();
    int cycles = 0;
    int p, qs;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      #1;
      if (o_inst_ready) break;
      cycles++;
      p  = c / 12;
      qs = c % 12;
      chk("conv_addr", {o_ifmap_ra, o_wght_ra, o_psum_ra, o_psum_wa, o_rst_psum, o_psum_we},
          {4'(qs), 8'(qs * 6 + p), 5'(p), 5'(p), (qs == 0), 1'b1});
    end
    chk("conv_cycles", cycles, 72);
  endtask

  initial begin
    #12;
    chk("rst_ready", o_inst_ready, 1);
    chk("rst_outs", {o_ifmap_fifo_ready, o_wght_fifo_ready, o_psum_in_fifo_ready, o_psum_out_valid,
        o_ifmap_mux_select, o_wght_mux_select, o_psum_in_mux_select, o_psum_out_demux_select,
        o_ifmap_ra, o_ifmap_wa, o_wght_ra, o_wght_wa, o_psum_ra, o_psum_wa,
        o_ifmap_we, o_wght_we, o_psum_we, o_acc_sel, o_rst_psum, o_err}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // CONV with no configuration is rejected
    issue(3'b100, 0, 0, 0);
    chk("noc_dec_we", o_psum_we, 0);
    @(negedge i_clk);
    chk("noc_err", o_err, 1);
    chk("noc_ready", o_inst_ready, 1);
    chk("noc_we", o_psum_we, 0);

    issue(3'b001, 6, 4, 3);
    chk("set_dec_ready", o_inst_ready, 0);
    @(negedge i_clk);
    chk("set_ready", o_inst_ready, 1);
    chk("set_err_clr", o_err, 0);

    issue(3'b010, 0, 0, 0);
    stream(0, 1'b1, 12, 23, "ldi");
    issue(3'b011, 0, 0, 0);
    stream(1, 1'b0, 72, 72, "ldw");
    issue(3'b100, 0, 0, 0);
    run_conv();
    issue(3'b101, 0, 0, 0);
    stream(2, 1'b0, 6, 6, "acc");

`ifdef PE_CTRL_DRAIN_EN
    issue(3'b110, 0, 0, 0);
    stream(3, 1'b1, 6, 11, "drn");
    chk("drn_err", o_err, 0);
`else
    issue(3'b110, 0, 0, 0);
    chk("drn_off_valid", o_psum_out_valid, 0);
    @(negedge i_clk);
    chk("drn_off_err", o_err, 1);
    chk("drn_off_ready", o_inst_ready, 1);
`endif

    // Q*S=20 exceeds the 16-entry ifmap spad; old configuration must survive
    issue(3'b001, 2, 5, 4);
    @(negedge i_clk);
    chk("badset_err", o_err, 1);
    issue(3'b010, 0, 0, 0);
    stream(0, 1'b0, 12, 12, "ldi_kept");
    chk("err_sticky", o_err, 1);

    issue(3'b001, 0, 4, 3);
    @(negedge i_clk);
    chk("p0_err", o_err, 1);

    issue(3'b111, 0, 0, 0);
    @(negedge i_clk);
    chk("op7_err", o_err, 1);
    chk("op7_ready", o_inst_ready, 1);

    // Q*S exactly fills the ifmap spad
    issue(3'b001, 1, 4, 4);
    @(negedge i_clk);
    chk("edge_set_err", o_err, 0);
    issue(3'b010, 0, 0, 0);
    stream(0, 1'b0, 16, 16, "ldi_full");

    issue(3'b001, 6, 4, 3);
    @(negedge i_clk);
    chk("reset_set_err", o_err, 0);

    // Reset in the middle of a weight load
    issue(3'b011, 0, 0, 0);
    i_wght_fifo_valid = 1'b1;
    repeat (5) @(negedge i_clk);
    #1;
    chk("mid_we_before", o_wght_we, 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_we", o_wght_we, 0);
    chk("mid_rst_ready", o_inst_ready, 1);
    @(negedge i_clk);
    chk("mid_rst_we2", o_wght_we, 0);
    i_wght_fifo_valid = 1'b0;
    i_rst_n = 1'b1;

    issue(3'b010, 0, 0, 0);
    chk("post_rst_ifwe", o_ifmap_we, 0);
    @(negedge i_clk);
    chk("post_rst_err", o_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
